// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shift-add multiplier.
// Ports: clk, rst (async high), req0/a0/b0, req1/a1/b1 requests;
//        gnt0/gnt1 capture pulses, busy, product, done pulse, done_id owner.
module mult_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               busy,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               done_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               owner;
  logic               last;

  logic               pick0;
  logic               pick1;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] sum;

  // last=1 means requester 1 was served most recently, so 0 wins a tie
  always_comb begin
    pick0  = req0 & (~req1 | last);
    pick1  = req1 & ~pick0;
    addend = '0;
    if (b_q[cnt])
      addend = {{WIDTH{1'b0}}, a_q} << cnt;
    sum = acc + addend;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      owner   <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      product <= '0;
      done    <= 1'b0;
      done_id <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick0 | pick1) begin
            a_q   <= pick0 ? a0 : a1;
            b_q   <= pick0 ? b0 : b1;
            acc   <= '0;
            cnt   <= '0;
            owner <= pick1;
            last  <= pick1;
            gnt0  <= pick0;
            gnt1  <= pick1;
            busy  <= 1'b1;
            state <= MULT;
          end
        end
        MULT: begin
          acc <= sum;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            product <= sum;
            done_id <= owner;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; product width is 2*WIDTH.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req0, input, 1 bit: requester 0 asks for a multiply.
REQ-005 The block SHALL have ports a0 and b0, input, WIDTH bits each: requester 0 multiplicand and multiplier.
REQ-006 The block SHALL have port req1, input, 1 bit: requester 1 asks for a multiply.
REQ-007 The block SHALL have ports a1 and b1, input, WIDTH bits each: requester 1 multiplicand and multiplier.
REQ-008 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle pulse when that requester's operands are captured.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port product, output, 2*WIDTH bits: result of the last completed multiply.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when product is updated.
REQ-012 The block SHALL have port done_id, output, 1 bit: requester index (0 or 1) owning the current product.

Function
REQ-013 The block SHALL implement the states IDLE, MULT and DONE.
REQ-014 In IDLE with no request: remain in IDLE with all pulse outputs low.
REQ-015 In IDLE with one request: grant that requester.
REQ-016 In IDLE with both requests: round-robin arbitration; grant the requester not served last; last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-017 On the granting edge: capture the winner's a/b into internal registers, clear the accumulator, clear the step counter, record the owner, update the last-served pointer, go to MULT, and assert the matching gnt for exactly the following cycle.
REQ-018 In MULT, each edge SHALL perform one shift-add step: if multiplier bit[count]=1, add (zero-extended a << count) to the 2*WIDTH-bit accumulator; then increment count.
REQ-019 The accumulator SHALL be 2*WIDTH bits; no overflow is possible (max (2^WIDTH-1)^2).
REQ-020 On the edge performing step count=WIDTH-1, the block SHALL load product with the final sum, load done_id with the owner, go to DONE, and raise done for exactly one cycle.
REQ-021 DONE SHALL return to IDLE on the next edge unconditionally; requests are sampled only in IDLE.
REQ-022 Latency SHALL be fixed: with the grant edge as E0, done is high in the cycle after edge E_WIDTH, independent of operand values; the next grant occurs no earlier than edge E_WIDTH+2.
REQ-023 Requests arriving while busy=1 SHALL be neither granted nor lost; a requester holds req, a and b until its gnt, and operand changes after the grant edge have no effect.
REQ-024 product and done_id SHALL hold their values between done pulses.
REQ-025 gnt0 and gnt1 SHALL never be high in the same cycle, and at most one operation SHALL be in flight.
REQ-026 Zero operands SHALL follow the same timing and yield product 0.

Reset
REQ-027 While rst=1, independent of clk: state IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0, product=0, accumulator and counter 0, last-served pointer=1.
REQ-028 Reset asserted mid-MULT SHALL abort the operation without a done pulse; after release, the first grant follows REQ-016 from the reset pointer.

Verification
REQ-029 req0=1, a0=4'd3, b0=4'd5 from IDLE -> gnt0 pulse, busy=1, 4 cycles later done=1, product=8'd15, done_id=0.
REQ-030 req1=1, a1=4'd15, b1=4'd15 -> product=8'd225, done_id=1; a1=0, b1=4'd9 -> product=0 with identical timing.
REQ-031 req0 and req1 held high continuously with distinct operands -> grants alternate 0,1,0,1 with gaps of WIDTH+2 cycles, and each done_id matches its grant.
REQ-032 req1 raised while busy serving requester 0 -> no gnt1 until IDLE; gnt1 follows at the first IDLE edge; a0 changed after gnt0 does not alter the product.
REQ-033 rst pulsed two cycles into MULT -> all outputs 0 at once, no done pulse; after release, simultaneous requests grant requester 0 first.
